// File: rtl/if_stage.sv
// Instruction fetch stage with a run/step/halt control FSM.
// Owns the PC, fetches from an asynchronous-read instruction memory and
// loads the IF/ID pipeline register. The FSM gates every advance of the
// pipeline through o_pipe_en, so downstream stages share one enable.
//
// Pipeline contract: o_pipe_en is the single advance strobe. A downstream
// register captures only when o_pipe_en=1. o_valid_id qualifies the IF/ID
// contents: 1 = real instruction, 0 = bubble (instr and pc4 are zero).
// No ready/backpressure exists besides i_stall from the hazard unit.
module if_stage #(
  parameter int                 NB_PC      = 32,
  parameter logic [NB_PC-1:0]   HALT_INSTR = {NB_PC{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [NB_PC-1:0] i_target,
  output logic [NB_PC-1:0] o_imem_addr,
  input  logic [NB_PC-1:0] i_imem_data,
  output logic [NB_PC-1:0] o_instr_id,
  output logic [NB_PC-1:0] o_pc4_id,
  output logic             o_valid_id,
  output logic             o_pipe_en,
  output logic             o_halted,
  output logic [1:0]       o_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [NB_PC-1:0] pc_q, pc_d;
  logic [NB_PC-1:0] instr_q, instr_d;
  logic [NB_PC-1:0] pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             en;
  logic [NB_PC-1:0] pc_plus4;
  logic             is_halt;

  // PC+4 wraps naturally at the register width; low two bits stay zero
  // because the PC only ever loads 0, PC+4 or a word-aligned target.
  assign pc_plus4 = pc_q + NB_PC'(4);
  assign is_halt  = (i_imem_data == HALT_INSTR);

  // Advance enable per FSM state; HALTED keeps advancing so bubbles drain.
  always_comb begin
    en = 1'b0;
    case (state_q)
      ST_IDLE: en = 1'b0;
      ST_RUN:  en = 1'b1;
      ST_STEP: en = i_step;
      ST_HALT: en = 1'b1;
      default: en = 1'b0;
    endcase
  end

  // Next-state for PC, IF/ID and FSM; stall beats flush, flush beats fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = i_step_mode ? ST_STEP : ST_RUN;
        end
      end
      ST_HALT: begin
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        if (en && !i_stall) begin
          if (i_flush) begin
            pc_d    = {i_target[NB_PC-1:2], 2'b00};
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
          end else begin
            instr_d = i_imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            if (is_halt) begin
              state_d = ST_HALT;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign o_imem_addr = pc_q;
  assign o_instr_id  = instr_q;
  assign o_pc4_id    = pc4_q;
  assign o_valid_id  = valid_q;
  assign o_pipe_en   = en;
  assign o_halted    = (state_q == ST_HALT);
  assign o_state     = state_q;

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
module tb_if_stage;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [31:0] NO_HALT = 32'h00000001; // unaligned, never fetched

  // ---------------- clock / reset / signals ----------------
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0, i_step_mode = 1'b0, i_step = 1'b0;
  logic        i_stall = 1'b0, i_flush = 1'b0;
  logic [31:0] i_target = '0;
  logic [31:0] i_imem_data;
  logic [31:0] o_imem_addr, o_instr_id, o_pc4_id;
  logic        o_valid_id, o_pipe_en, o_halted;
  logic [1:0]  o_state;
  logic [31:0] halt_addr = NO_HALT;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  if_stage #(.NB_PC(32), .HALT_INSTR(32'hFFFFFFFF)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_stall(i_stall), .i_flush(i_flush), .i_target(i_target),
    .o_imem_addr(o_imem_addr), .i_imem_data(i_imem_data), .o_instr_id(o_instr_id),
    .o_pc4_id(o_pc4_id), .o_valid_id(o_valid_id), .o_pipe_en(o_pipe_en),
    .o_halted(o_halted), .o_state(o_state)
  );

  // Program memory: word k holds k+1, except one optional halt location.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] h);
    if (a == h) return HALT;
    return {2'b00, a[31:2]} + 32'd1;
  endfunction

  assign i_imem_data = mem_word(o_imem_addr, halt_addr);

  // ---------------- reference model ----------------
  // Architectural view: current PC, IF/ID contents and mode (0 idle,
  // 1 run, 2 step, 3 halted). Updated once per rising edge.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_state;

  wire [100:0] dut_vec = {o_imem_addr, o_instr_id, o_pc4_id, o_valid_id,
                          o_pipe_en, o_halted, o_state};

  function automatic logic exp_en();
    if (m_state == 1 || m_state == 3) return 1'b1;
    if (m_state == 2) return i_step;
    return 1'b0;
  endfunction

  function automatic logic [100:0] exp_vec();
    logic h;
    h = (m_state == 3);
    return {m_pc, m_instr, m_pc4, m_valid, exp_en(), h, 2'(m_state)};
  endfunction

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_state = 0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (m_state == 0) begin
      if (i_start) m_state = i_step_mode ? 2 : 1;
    end else if (m_state == 3) begin
      m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (exp_en() && !i_stall) begin
      if (i_flush) begin
        m_pc = i_target & ~32'd3;
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
      end else begin
        w = mem_word(m_pc, halt_addr);
        m_instr = w;
        m_pc4 = m_pc + 32'd4;
        m_valid = 1'b1;
        if (w == HALT) m_state = 3;
        else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    if (i_rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle_inputs();
    i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
    i_stall = 1'b0; i_flush = 1'b0; i_target = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1'b1;
    model_reset();
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic start_run(input logic step_mode);
    i_start = 1'b1; i_step_mode = step_mode;
    tick();
    i_start = 1'b0; i_step_mode = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    i_start = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 101'd0) begin
      failures++;
      $display("FAIL reset_zero got=%h exp=0", dut_vec);
    end
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", dut_vec, exp_vec());
    end
    i_rst = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic test_run_seq();
    do_reset();
    start_run(1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (o_imem_addr !== 32'(4 * k) || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL run_seq k=%0d got=%h exp=%h addr=%h", k, dut_vec, exp_vec(), o_imem_addr);
      end
      tick();
      checks++;
      if ({o_instr_id, o_pc4_id, o_valid_id} !== {32'(k + 1), 32'(4 * k + 4), 1'b1}) begin
        failures++;
        $display("FAIL run_seq_ifid k=%0d got=%h/%h/%b exp=%0d/%0d/1",
                 k, o_instr_id, o_pc4_id, o_valid_id, k + 1, 4 * k + 4);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    start_run(1'b0);
    tick(); tick();
    i_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({o_imem_addr, o_instr_id, o_pc4_id} !== {32'd8, 32'd2, 32'd8} || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL stall_hold k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    i_stall = 1'b0;
    tick();
    checks++;
    if ({o_imem_addr, o_instr_id} !== {32'd12, 32'd3}) begin
      failures++;
      $display("FAIL stall_resume got=%h/%h exp=c/3", o_imem_addr, o_instr_id);
    end
  endtask

  task automatic test_flush();
    do_reset();
    start_run(1'b0);
    repeat (4) tick();
    i_flush = 1'b1; i_target = 32'h43;
    tick();
    checks++;
    if ({o_imem_addr, o_instr_id, o_pc4_id, o_valid_id} !== {32'h40, 32'd0, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL flush_redirect got=%h/%h/%h/%b exp=40/0/0/0",
               o_imem_addr, o_instr_id, o_pc4_id, o_valid_id);
    end
    i_stall = 1'b1; i_target = 32'h80;
    tick();
    checks++;
    if (o_imem_addr !== 32'h40 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL flush_under_stall got=%h exp=%h", dut_vec, exp_vec());
    end
    idle_inputs();
    tick();
    checks++;
    if ({o_imem_addr, o_instr_id, o_pc4_id} !== {32'h44, 32'h11, 32'h44}) begin
      failures++;
      $display("FAIL flush_refetch got=%h/%h/%h exp=44/11/44", o_imem_addr, o_instr_id, o_pc4_id);
    end
  endtask

  task automatic test_halt();
    halt_addr = 32'h0C;
    do_reset();
    start_run(1'b0);
    repeat (3) tick();
    // Halt word visible but stalled: must not halt.
    i_stall = 1'b1;
    tick();
    checks++;
    if (o_state !== 2'd1 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL halt_stalled got=%h exp=%h", dut_vec, exp_vec());
    end
    i_stall = 1'b0;
    tick();
    checks++;
    if ({o_instr_id, o_valid_id, o_imem_addr, o_halted, o_state} !== {HALT, 1'b1, 32'h0C, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL halt_detect got=%h/%b/%h/%b/%0d exp=ffffffff/1/c/1/3",
               o_instr_id, o_valid_id, o_imem_addr, o_halted, o_state);
    end
    for (int k = 0; k < 3; k++) begin
      i_start = 1'b1; i_stall = k[0]; i_flush = 1'b1; i_target = 32'h100;
      #1;
      checks++;
      if (o_pipe_en !== 1'b1) begin
        failures++;
        $display("FAIL halt_pipe_en k=%0d got=%b exp=1", k, o_pipe_en);
      end
      tick();
      checks++;
      if ({o_instr_id, o_pc4_id, o_valid_id, o_imem_addr, o_state} !== {32'd0, 32'd0, 1'b0, 32'h0C, 2'd3}) begin
        failures++;
        $display("FAIL halt_bubble k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    idle_inputs();
    halt_addr = NO_HALT;
  endtask

  task automatic test_step();
    do_reset();
    start_run(1'b1);
    for (int c = 0; c < 9; c++) begin
      i_step = (c == 1 || c == 4 || c == 7);
      #1;
      checks++;
      if (o_pipe_en !== i_step || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL step_pulse c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      tick();
    end
    checks++;
    if ({o_imem_addr, o_instr_id, o_state} !== {32'd12, 32'd3, 2'd2}) begin
      failures++;
      $display("FAIL step_final got=%h/%h/%0d exp=c/3/2", o_imem_addr, o_instr_id, o_state);
    end
    i_step = 1'b1;
    repeat (3) tick();
    i_step = 1'b0;
    #1;
    checks++;
    if (o_imem_addr !== 32'd24 || o_pipe_en !== 1'b0) begin
      failures++;
      $display("FAIL step_held got=%h/%b exp=18/0", o_imem_addr, o_pipe_en);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_run(1'b0);
    repeat (8) tick();
    #2;
    i_rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 101'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", dut_vec);
    end
    tick();
    i_rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (o_state !== 2'd0 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_wait_idle got=%h exp=%h", dut_vec, exp_vec());
    end
    // Wrap: redirect to the last word, then fetch it.
    start_run(1'b0);
    i_flush = 1'b1; i_target = 32'hFFFFFFFF;
    tick();
    i_flush = 1'b0;
    tick();
    checks++;
    if ({o_imem_addr, o_instr_id, o_pc4_id, o_valid_id} !== {32'd0, 32'h40000000, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL pc_wrap got=%h/%h/%h/%b exp=0/40000000/0/1",
               o_imem_addr, o_instr_id, o_pc4_id, o_valid_id);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    halt_addr = {24'd0, 6'($urandom_range(6, 40)), 2'b00};
    do_reset();
    for (int c = 0; c < 600; c++) begin
      i_rst       = ($urandom_range(0, 79) == 0);
      i_start     = ($urandom_range(0, 5) == 0);
      i_step_mode = $urandom_range(0, 1);
      i_step      = $urandom_range(0, 1);
      i_stall     = ($urandom_range(0, 4) == 0);
      i_flush     = ($urandom_range(0, 6) == 0);
      i_target    = {25'd0, 7'($urandom_range(0, 127))};
      if (i_rst) begin
        model_reset();
        halt_addr = {24'd0, 6'($urandom_range(6, 40)), 2'b00};
      end
      #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        bad++;
        if (bad < 6) $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      tick();
    end
    idle_inputs();
    i_rst = 1'b0;
    halt_addr = NO_HALT;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_run_seq();
    test_stall();
    test_flush();
    test_halt();
    test_step();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
